// File: rtl/matrix_stream_deserializer_pkg.sv
// Shared types and defaults for the matrix stream deserializer.
// Holds FSM state enum, default geometry and the flat slot-offset helper.
package mat_pkg;

  localparam int H_DEF = 4;
  localparam int W_DEF = 3;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int FRACT_WIDTH_DEF = 8;
  localparam int NELEM = H_DEF * W_DEF;

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

  // Bit offset of element (r,c) in the row-major flat matrix bus.
  function automatic int slot_off(
    input int r,
    input int c,
    input int w,
    input int dw
  );
    return (r * w + c) * dw;
  endfunction

endpackage

// File: rtl/matrix_stream_deserializer.sv
// Collects a serial element stream into one flat row-major H x W matrix.
// Ports: clk/rst_n, s_data/s_valid/s_last/s_ready in, m_mat/m_valid/m_ready out, err_len, elem_cnt.
module matrix_stream_deserializer
  import mat_pkg::*;
#(
  parameter int H          = H_DEF,
  parameter int W          = W_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH-1:0]         s_data,
  input  logic                          s_valid,
  input  logic                          s_last,
  output logic                          s_ready,
  output logic [H*W*DATA_WIDTH-1:0]     m_mat,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          err_len,
  output logic [$clog2(H*W+1)-1:0]      elem_cnt
);

  localparam int N  = H * W;
  localparam int CW = $clog2(N + 1);

  state_t          state;
  state_t          state_nxt;
  logic            in_xfer;
  logic            out_xfer;
  logic            at_end;
  logic [CW-1:0]   slot;

  assign in_xfer  = s_valid & s_ready;
  assign out_xfer = m_valid & m_ready;

  // In FULL an accepted element is the handoff into slot 0.
  assign slot   = (state == FULL) ? '0 : elem_cnt;
  assign at_end = (slot == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      COLLECT: begin
        if (in_xfer && at_end) state_nxt = FULL;
      end
      FULL: begin
        if (in_xfer && at_end) state_nxt = FULL;
        else if (out_xfer)     state_nxt = COLLECT;
      end
    endcase
  end

  always_comb begin
    s_ready = 1'b1;
    m_valid = 1'b0;
    unique case (state)
      COLLECT: begin
        s_ready = 1'b1;
        m_valid = 1'b0;
      end
      FULL: begin
        s_ready = m_ready;
        m_valid = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem_cnt <= '0;
      err_len  <= 1'b0;
      m_mat    <= '0;
    end else begin
      err_len <= 1'b0;
      if (out_xfer) elem_cnt <= '0;
      if (in_xfer) begin
        for (int r = 0; r < H; r++) begin
          for (int c = 0; c < W; c++) begin
            if (slot == CW'(r * W + c))
              m_mat[slot_off(r, c, W, DATA_WIDTH) +: DATA_WIDTH] <= s_data;
          end
        end
        if (at_end) begin
          elem_cnt <= CW'(N);
          err_len  <= ~s_last;
        end else if (s_last) begin
          // Early end: drop the partial matrix.
          elem_cnt <= '0;
          err_len  <= 1'b1;
        end else begin
          elem_cnt <= slot + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_stream_deserializer.sv
// Self-checking bench for matrix_stream_deserializer.
// Directed scenarios then random traffic against a queue/array reference model.
module tb_matrix_stream_deserializer;

  localparam int H  = 4;
  localparam int W  = 3;
  localparam int DW = 16;
  localparam int N  = H * W;
  localparam int CW = $clog2(N + 1);

  logic                clk;
  logic                rst_n;
  logic [DW-1:0]       s_data;
  logic                s_valid;
  logic                s_last;
  logic                s_ready;
  logic [N*DW-1:0]     m_mat;
  logic                m_valid;
  logic                m_ready;
  logic                err_len;
  logic [CW-1:0]       elem_cnt;

  matrix_stream_deserializer #(
    .H(H),
    .W(W),
    .DATA_WIDTH(DW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_last(s_last),
    .s_ready(s_ready),
    .m_mat(m_mat),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .err_len(err_len),
    .elem_cnt(elem_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mmat [N];
  int            mcnt;
  bit            mfull;
  bit            merr;

  function automatic logic [N*DW-1:0] packed_model();
    logic [N*DW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = mmat[i];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [N*DW-1:0] obs,
                     input logic [N*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) mmat[i] = '0;
    mcnt  = 0;
    mfull = 0;
    merr  = 0;
  endtask

  // One clock: drive, check s_ready, update model at the edge, check outputs.
  task automatic step(input bit sv, input logic [DW-1:0] sd,
                      input bit sl, input bit mr);
    bit rdy;
    bit ix;
    bit ox;
    s_valid = sv;
    s_data  = sd;
    s_last  = sl;
    m_ready = mr;
    #1;
    rdy = !mfull || mr;
    chk("s_ready", {191'b0, s_ready}, {191'b0, rdy});
    @(posedge clk);
    ix   = sv && rdy;
    ox   = mfull && mr;
    merr = 0;
    if (ox) begin
      mfull = 0;
      mcnt  = 0;
    end
    if (ix) begin
      mmat[mcnt] = sd;
      mcnt++;
      if (mcnt == N) begin
        mfull = 1;
        merr  = !sl;
      end else if (sl) begin
        merr = 1;
        mcnt = 0;
      end
    end
    #1;
    chk("m_valid", {191'b0, m_valid}, {191'b0, mfull});
    chk("err_len", {191'b0, err_len}, {191'b0, merr});
    chk("elem_cnt", {{(N*DW-CW){1'b0}}, elem_cnt}, (N*DW)'(mcnt));
    if (mfull) chk("m_mat", m_mat, packed_model());
  endtask

  task automatic idle(input bit mr);
    step(1'b0, 16'h0000, 1'b0, mr);
  endtask

  initial begin
    bit nat;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    model_reset();
    #3;
    chk("rst_m_valid", {191'b0, m_valid}, '0);
    chk("rst_m_mat", m_mat, '0);
    chk("rst_err_len", {191'b0, err_len}, '0);
    chk("rst_elem_cnt", {{(N*DW-CW){1'b0}}, elem_cnt}, '0);
    rst_n = 1'b1;

    // 12 x 0.25 back-to-back, consumer ready
    for (int i = 0; i < N; i++) step(1'b1, 16'h0040, i == N - 1, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // alternating 0.75/-0.25, consumer stalls with extra s_valid
    for (int i = 0; i < N; i++)
      step(1'b1, (i % 2 == 0) ? 16'h00C0 : 16'hFFC0, i == N - 1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 16'hDEAD, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // two matrices back-to-back with handoff
    for (int i = 0; i < 2 * N; i++)
      step(1'b1, 16'h1000 + 16'(i), (i % N) == N - 1, 1'b1);
    idle(1'b1);

    // early s_last on the 5th element, then a good matrix
    for (int i = 0; i < 5; i++) step(1'b1, 16'h0500 + 16'(i), i == 4, 1'b1);
    for (int i = 0; i < N; i++) step(1'b1, 16'h0A00 + 16'(i), i == N - 1, 1'b1);
    idle(1'b1);

    // missing s_last
    for (int i = 0; i < N; i++) step(1'b1, 16'h0B00 + 16'(i), 1'b0, 1'b1);
    idle(1'b1);

    // async reset mid-matrix
    for (int i = 0; i < 7; i++) step(1'b1, 16'h0C00 + 16'(i), 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_m_valid", {191'b0, m_valid}, '0);
    chk("mid_rst_elem_cnt", {{(N*DW-CW){1'b0}}, elem_cnt}, '0);
    chk("mid_rst_m_mat", m_mat, '0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) step(1'b1, 16'h0D00 + 16'(i), i == N - 1, 1'b1);
    idle(1'b1);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      nat = mfull ? (N == 1) : (mcnt == N - 1);
      step(($urandom % 4) != 0, 16'($urandom),
           (($urandom % 16) == 0) ? !nat : nat,
           ($urandom % 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
